// File: rtl/fft_stream_master_pkg.sv
// Shared types for the FFT stream master: burst codes, FSM states, result entry.
package fft_pkg;
    localparam int SAMP_W = 12;

    typedef enum logic [1:0] {
        MID    = 2'b00,
        FIRST  = 2'b01,
        LAST   = 2'b10,
        SINGLE = 2'b11
    } burst_e;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

    typedef struct packed {
        logic [31:0]       data;
        logic [SAMP_W-1:0] idx;
    } res_entry_t;

    function automatic burst_e burst_code(input logic [SAMP_W-1:0] beat,
                                          input logic [SAMP_W-1:0] len);
        if (len == SAMP_W'(1)) return SINGLE;
        if (beat == '0) return FIRST;
        if (beat == len - SAMP_W'(1)) return LAST;
        return MID;
    endfunction
endpackage

// File: rtl/fft_stream_master_if.sv
// Sample source, FFT write/read channels and result sink of the stream master.
interface fft_stream_if import fft_pkg::*; #(parameter int N = 2);
    logic [15:0]       src_data;
    logic              src_valid, src_ready;
    logic [15:0]       WDATA;
    logic              WVALID, WREADY;
    logic [N-1:0]      WBURST;
    logic [31:0]       RDATA;
    logic              RVALID, RREADY;
    logic [N-1:0]      RBURST;
    logic [31:0]       res_data;
    logic [SAMP_W-1:0] res_index;
    logic              res_valid, res_ready;

    modport master (
        input  src_data, src_valid, output src_ready,
        output WDATA, WVALID, WBURST, input WREADY,
        input  RDATA, RVALID, RBURST, output RREADY,
        output res_data, res_index, res_valid, input res_ready
    );
    modport slave (
        output src_data, src_valid, input src_ready,
        input  WDATA, WVALID, WBURST, output WREADY,
        output RDATA, RVALID, RBURST, input RREADY,
        input  res_data, res_index, res_valid, output res_ready
    );
endinterface

// File: rtl/fft_stream_master_res_fifo.sv
// First-word fall-through result buffer; extra pointer bit separates full from empty.
module fft_res_fifo #(
    parameter int WIDTH      = 44,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             n_Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fft_stream_master.sv
// Streams one frame of samples into an FFT core, collects the results and
// forwards them with their index through a small FWFT buffer.
module fft_stream_master import fft_pkg::*; #(
    parameter int N          = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              n_Reset,
    input  logic              start,
    input  logic [SAMP_W-1:0] samp_number,
    fft_stream_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              burst_err
);
    state_e            state_q, state_d;
    logic [SAMP_W-1:0] len_q, sent_q, wcnt_q, rcnt_q, last_beat;
    logic [15:0]       wdata_q;
    logic              wvalid_q;
    logic [N-1:0]      wburst_q;
    logic              done_q, berr_q;
    logic              src_ready_c, rready_c, accept;
    logic              src_hs, w_hs, r_hs, pop, fifo_full, fifo_empty;
    res_entry_t        push_ent, pop_ent;

    assign last_beat = len_q - SAMP_W'(1);
    assign accept    = (state_q == IDLE) && start;
    assign src_hs    = bus.src_valid && src_ready_c;
    assign w_hs      = wvalid_q && bus.WREADY;
    assign r_hs      = bus.RVALID && rready_c;
    assign pop       = !fifo_empty && bus.res_ready;

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        src_ready_c = 1'b0;
        rready_c    = 1'b0;
        case (state_q)
            IDLE:  if (start && samp_number != '0) state_d = WRITE;
            WRITE: begin
                src_ready_c = (!wvalid_q || bus.WREADY) && (sent_q < len_q);
                if (w_hs && wcnt_q == last_beat) state_d = READ;
            end
            READ: begin
                rready_c = !fifo_full;
                if (r_hs && rcnt_q == last_beat) state_d = DRAIN;
            end
            DRAIN: if (fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            len_q    <= '0;
            sent_q   <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            wburst_q <= '0;
            done_q   <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            // a zero-length request completes on the spot without touching either channel
            done_q <= (accept && samp_number == '0) || (state_q == DRAIN && fifo_empty);
            if (accept) begin
                len_q  <= samp_number;
                sent_q <= '0;
                wcnt_q <= '0;
                rcnt_q <= '0;
                berr_q <= 1'b0;
            end
            if (src_hs) begin
                wdata_q  <= bus.src_data;
                wvalid_q <= 1'b1;
                wburst_q <= N'(burst_code(sent_q, len_q));
                sent_q   <= sent_q + SAMP_W'(1);
            end else if (w_hs) begin
                wvalid_q <= 1'b0;
            end
            if (w_hs) wcnt_q <= wcnt_q + SAMP_W'(1);
            if (r_hs) begin
                rcnt_q <= rcnt_q + SAMP_W'(1);
                if (bus.RBURST != N'(burst_code(rcnt_q, len_q))) berr_q <= 1'b1;
            end
        end
    end

    assign push_ent = '{data: bus.RDATA, idx: rcnt_q};

    fft_res_fifo #(
        .WIDTH      ($bits(res_entry_t)),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .n_Reset (n_Reset),
        .push    (r_hs),
        .din     (push_ent),
        .pop     (pop),
        .dout    (pop_ent),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.src_ready = src_ready_c;
    assign bus.WDATA     = wdata_q;
    assign bus.WVALID    = wvalid_q;
    assign bus.WBURST    = wburst_q;
    assign bus.RREADY    = rready_c;
    assign bus.res_data  = pop_ent.data;
    assign bus.res_index = pop_ent.idx;
    assign bus.res_valid = !fifo_empty;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign burst_err     = berr_q;
endmodule
